jtag_tap_ctrl: RTL and testbench
================================

// Module: jtag_tap_ctrl
// PURPOSE
//  IEEE 1149.1 TAP controller. Sits directly upstream of the boundary-scan cells, IR and ID.
//  - 16-state FSM stepped by TMS.
//  - Generates shiftdr/clockdr/updatedr, shiftir-clock/updateir, bs_en.
//  - Selects the scan path and registers TDO.
// PARAMETERS
//  IR_W      2     instruction width; must match the sel width from ID
//  EXTEST    2'b00 opcode for EXTEST: drives bs_en=1
//  BYPASS    2'b11 opcode for BYPASS: used only when TAP_BYPASS_EN is defined
// PORTS
//  TCK       in   1     test clock; the only clock
//  TRST_N    in   1     asynchronous, active-low reset
//  TMS       in   1     mode select, sampled on posedge TCK
//  TDI       in   1     serial in; feeds the bypass flop
//  sel       in   IR_W  decoded instruction from ID
//  ir_tdo    in   1     serial out of the IR chain
//  bsr_tdo   in   1     serial out of the last SFF in the boundary chain
//  shiftdr   out  1     SFF shift/load select
//  clockdr   out  1     gated capture/shift clock to the SFFs
//  updatedr  out  1     gated update clock to the SFFs
//  clockir   out  1     gated shift clock to IR (drives the IR shiftir input)
//  updateir  out  1     gated update clock to IR
//  bs_en     out  1     SFF test/normal select
//  TDO       out  1     serial out, registered
//  tdo_oe    out  1     TDO valid/drive enable
// BEHAVIOUR
//  - State register updates on posedge TCK. On TRST_N=0 it goes to TEST_LOGIC_RESET immediately.
//  - Transitions, written as TMS=0 / TMS=1:
//    TLR:RTI/TLR  RTI:RTI/SELDR  SELDR:CAPDR/SELIR  SELIR:CAPIR/TLR
//    CAPx:SHx/EX1x  SHx:SHx/EX1x  EX1x:PAUx/UPDx  PAUx:PAUx/EX2x
//    EX2x:SHx/UPDx  UPDx:RTI/SELDR   (x = DR or IR)
//  - From any state, 5 TCKs with TMS=1 reach TLR.
//  - Gated clocks are combinational from the state register and TCK:
//    - clockdr = TCK | ~(CAPDR|SHDR). Its rising edge coincides with posedge TCK.
//    - clockir = TCK | ~(CAPIR|SHIR).
//    - updatedr = ~TCK & UPDDR. One pulse, rising on negedge TCK while in UPDDR.
//    - updateir = ~TCK & UPDIR.
//    - Idle level of clockdr/clockir is 1; idle level of updatedr/updateir is 0.
//  - Registered on negedge TCK:
//    - shiftdr = (state==SHDR).
//    - tdo_oe = (state==SHDR|SHIR).
//    - bs_en = (sel==EXTEST) & (state!=TLR).
//    - These lag the state by half a TCK.
//  - TDO is registered on negedge TCK:
//    - SHIR: TDO = ir_tdo.
//    - SHDR: TDO = bsr_tdo, or the bypass path (see CONFIGURATION).
//    - Any other state: TDO holds 0.
//  - Reset values (async, at TRST_N=0): state=TLR, shiftdr=0, bs_en=0, TDO=0, tdo_oe=0.
//    - Gated clocks go to their idle levels because the state is TLR.
//  - Reset mid-operation (for example in SHDR or UPDDR):
//    - No updatedr/updateir pulse is produced.
//    - Any in-flight update pulse is truncated.
//    - Downstream registers keep their last value.
//  - Pause states hold shiftdr=0 and tdo_oe=0; clockdr stays at 1.
//  - Latency: TMS edge to state change is 1 posedge. State to shiftdr/tdo_oe is +half TCK.
//    TDI to TDO through bypass is 1 TCK.
//  - sel may change only in UPDIR. It is sampled combinationally for bs_en on the next negedge.
// CONFIGURATION
//  Macro TAP_BYPASS_EN.
//  - Defined:
//    - A 1-bit bypass flop is clocked on posedge TCK.
//    - In CAPDR it loads 0; in SHDR it loads TDI.
//    - When sel==BYPASS, in SHDR: TDO = bypass flop, and clockdr/updatedr stay at their idle levels.
//  - Undefined:
//    - No bypass flop.
//    - The SHDR path is always bsr_tdo; the BYPASS opcode behaves like SAMPLE (bs_en=0).
// TESTING
//  1. TRST_N=0 from SHDR -> state TLR, shiftdr=0, tdo_oe=0, TDO=0, clockdr=1, updatedr=0.
//     Then from RTI, TMS=1 x5 -> TLR.
//  2. From TLR, TMS 0,1,0,0 -> SHDR; shiftdr=1 after the next negedge.
//     4 TCKs TMS=0 -> 4 clockdr rising edges aligned to posedge TCK.
//     Then TMS 1,1 -> exactly one updatedr pulse in UPDDR.
//  3. From RTI, TMS 1,1,0,0 -> SHIR; shift 2 bits with ir_tdo=1,0 -> TDO=1,0 on successive negedges.
//     TMS 1,1 -> exactly one updateir pulse; tdo_oe high only in SHIR.
//  4. TAP_BYPASS_EN, sel=2'b11: shift TDI=1,0,1,1 in SHDR -> TDO=0(capture),1,0,1 one TCK later.
//     No clockdr edges during the scan.
//  5. sel=EXTEST latched in UPDIR -> bs_en=1 at the next negedge.
//     TMS=1 x5 -> bs_en=0 once TLR is reached.
//  6. TRST_N=0 asserted during UPDDR with TCK low -> updatedr falls immediately; no second pulse.

Source files
------------

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: TMS-stepped 16-state FSM, gated scan clocks and a negedge TDO stage.
// Optional bypass register built when TAP_BYPASS_EN is defined.
module jtag_tap_ctrl #(
  parameter int              IR_W   = 2,
  parameter logic [IR_W-1:0] EXTEST = '0
`ifdef TAP_BYPASS_EN
  , parameter logic [IR_W-1:0] BYPASS = '1
`endif
) (
  input  logic            TCK,
  input  logic            TRST_N,
  input  logic            TMS,
  input  logic            TDI,
  input  logic [IR_W-1:0] sel,
  input  logic            ir_tdo,
  input  logic            bsr_tdo,
  output logic            shiftdr,
  output logic            clockdr,
  output logic            updatedr,
  output logic            clockir,
  output logic            updateir,
  output logic            bs_en,
  output logic            TDO,
  output logic            tdo_oe
);

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDDR,
    SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR
  } tap_st_e;

  tap_st_e state_q, state_d;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) state_q <= TLR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:   state_d = TMS ? TLR   : RTI;
      RTI:   state_d = TMS ? SELDR : RTI;
      SELDR: state_d = TMS ? SELIR : CAPDR;
      CAPDR: state_d = TMS ? EX1DR : SHDR;
      SHDR:  state_d = TMS ? EX1DR : SHDR;
      EX1DR: state_d = TMS ? UPDDR : PAUDR;
      PAUDR: state_d = TMS ? EX2DR : PAUDR;
      EX2DR: state_d = TMS ? UPDDR : SHDR;
      UPDDR: state_d = TMS ? SELDR : RTI;
      SELIR: state_d = TMS ? TLR   : CAPIR;
      CAPIR: state_d = TMS ? EX1IR : SHIR;
      SHIR:  state_d = TMS ? EX1IR : SHIR;
      EX1IR: state_d = TMS ? UPDIR : PAUIR;
      PAUIR: state_d = TMS ? EX2IR : PAUIR;
      EX2IR: state_d = TMS ? UPDIR : SHIR;
      UPDIR: state_d = TMS ? SELDR : RTI;
      default: state_d = TLR;
    endcase
  end

  logic byp_sel;
  logic dr_tdo;

`ifdef TAP_BYPASS_EN
  logic byp_q, byp_d;

  always_comb begin
    byp_d = byp_q;
    if (state_q == CAPDR)     byp_d = 1'b0;
    else if (state_q == SHDR) byp_d = TDI;
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) byp_q <= 1'b0;
    else         byp_q <= byp_d;
  end

  assign byp_sel = (sel == BYPASS);
  assign dr_tdo  = byp_sel ? byp_q : bsr_tdo;
`else
  logic unused_tdi;
  assign unused_tdi = TDI;
  assign byp_sel    = 1'b0;
  assign dr_tdo     = bsr_tdo;
`endif

  // With bypass selected the boundary chain is left untouched: no capture/shift/update clocks.
  assign clockdr  = TCK | ~(((state_q == CAPDR) | (state_q == SHDR)) & ~byp_sel);
  assign updatedr = ~TCK & (state_q == UPDDR) & ~byp_sel;
  assign clockir  = TCK | ~((state_q == CAPIR) | (state_q == SHIR));
  assign updateir = ~TCK & (state_q == UPDIR);

  logic shiftdr_q, tdo_oe_q, bs_en_q, tdo_q, tdo_d;

  always_comb begin
    tdo_d = 1'b0;
    if (state_q == SHIR)      tdo_d = ir_tdo;
    else if (state_q == SHDR) tdo_d = dr_tdo;
  end

  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      shiftdr_q <= 1'b0;
      tdo_oe_q  <= 1'b0;
      bs_en_q   <= 1'b0;
      tdo_q     <= 1'b0;
    end else begin
      shiftdr_q <= (state_q == SHDR);
      tdo_oe_q  <= (state_q == SHDR) | (state_q == SHIR);
      bs_en_q   <= (sel == EXTEST) & (state_q != TLR);
      tdo_q     <= tdo_d;
    end
  end

  assign shiftdr = shiftdr_q;
  assign tdo_oe  = tdo_oe_q;
  assign bs_en   = bs_en_q;
  assign TDO     = tdo_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed table-driven bench for jtag_tap_ctrl, plus hand sequences for reset and pulse-count corners.
module tb_jtag_tap_ctrl;

`ifdef TAP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       TCK, TRST_N, TMS, TDI, ir_tdo, bsr_tdo;
  logic [1:0] sel;
  logic       shiftdr, clockdr, updatedr, clockir, updateir, bs_en, TDO, tdo_oe;

  jtag_tap_ctrl dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .sel(sel),
    .ir_tdo(ir_tdo), .bsr_tdo(bsr_tdo),
    .shiftdr(shiftdr), .clockdr(clockdr), .updatedr(updatedr),
    .clockir(clockir), .updateir(updateir), .bs_en(bs_en),
    .TDO(TDO), .tdo_oe(tdo_oe)
  );

  logic [7:0] outs;
  assign outs = {shiftdr, tdo_oe, TDO, bs_en, clockdr, clockir, updatedr, updateir};

  int n_ckdr = 0, n_mis = 0, n_updr = 0, n_upir = 0;
  always @(posedge clockdr) begin
    n_ckdr++;
    if (TCK !== 1'b1) n_mis++;
  end
  always @(posedge updatedr) n_updr++;
  always @(posedge updateir) n_upir++;

  typedef struct {
    logic       tms, tdi, irt, bsrt;
    logic [1:0] sel;
    logic [7:0] exp;
  } vec_t;
  vec_t vq[$];

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic add(input logic tms, tdi, irt, bsrt, input logic [1:0] s,
                     input logic sh, oe, tdo, bs, cd, ci, ud, ui);
    vec_t v;
    v.tms = tms; v.tdi = tdi; v.irt = irt; v.bsrt = bsrt; v.sel = s;
    v.exp = {sh, oe, tdo, bs, cd, ci, ud, ui};
    vq.push_back(v);
  endtask

  // One TCK period; returns #1 after the negedge with TCK low.
  task automatic step(input logic tms, input logic tdi = 1'b0,
                      input logic irt = 1'b0, input logic bsrt = 1'b0);
    TMS = tms; TDI = tdi; ir_tdo = irt; bsr_tdo = bsrt;
    #4 TCK = 1'b1;
    #5 TCK = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    TRST_N = 1'b0;
    #3 TRST_N = 1'b1;
    #2;
  endtask

  int b_ckdr, b_mis, b_updr, b_upir;

  initial begin
    TCK = 0; TRST_N = 0; TMS = 1; TDI = 0; ir_tdo = 0; bsr_tdo = 0; sel = 2'b01;

    //   tms tdi irt bsr sel     sh oe tdo bs cd ci ud ui
    add(0, 0, 0, 0, 2'b01,  0, 0, 0, 0, 1, 1, 0, 0); // RTI
    add(1, 0, 0, 0, 2'b01,  0, 0, 0, 0, 1, 1, 0, 0); // SELDR
    add(0, 0, 0, 0, 2'b01,  0, 0, 0, 0, 0, 1, 0, 0); // CAPDR
    add(0, 0, 0, 1, 2'b01,  1, 1, 1, 0, 0, 1, 0, 0); // SHDR
    add(0, 0, 0, 0, 2'b01,  1, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 2'b01,  1, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 2'b01,  1, 1, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 2'b01,  0, 0, 0, 0, 1, 1, 0, 0); // EX1DR
    add(0, 0, 0, 1, 2'b01,  0, 0, 0, 0, 1, 1, 0, 0); // PAUDR
    add(1, 0, 0, 1, 2'b01,  0, 0, 0, 0, 1, 1, 0, 0); // EX2DR
    add(0, 0, 0, 0, 2'b01,  1, 1, 0, 0, 0, 1, 0, 0); // SHDR
    add(1, 0, 0, 0, 2'b01,  0, 0, 0, 0, 1, 1, 0, 0); // EX1DR
    add(1, 0, 0, 0, 2'b01,  0, 0, 0, 0, 1, 1, 1, 0); // UPDDR
    add(1, 0, 0, 0, 2'b01,  0, 0, 0, 0, 1, 1, 0, 0); // SELDR
    add(1, 0, 0, 0, 2'b01,  0, 0, 0, 0, 1, 1, 0, 0); // SELIR
    add(0, 0, 0, 0, 2'b01,  0, 0, 0, 0, 1, 0, 0, 0); // CAPIR
    add(0, 0, 1, 0, 2'b01,  0, 1, 1, 0, 1, 0, 0, 0); // SHIR
    add(0, 0, 0, 0, 2'b01,  0, 1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 2'b01,  0, 0, 0, 0, 1, 1, 0, 0); // EX1IR
    add(1, 0, 0, 0, 2'b01,  0, 0, 0, 0, 1, 1, 0, 1); // UPDIR
    add(0, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // RTI, EXTEST
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // SELDR
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // SELIR
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 0, 1, 1, 0, 0); // TLR
    add(0, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // RTI
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // SELDR
    add(0, 0, 0, 0, 2'b00,  0, 0, 0, 1, 0, 1, 0, 0); // CAPDR
    add(0, 0, 0, 1, 2'b00,  1, 1, 1, 1, 0, 1, 0, 0); // SHDR
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // EX1DR (5x TMS=1 from SHDR)
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 1, 0); // UPDDR
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // SELDR
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // SELIR
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 0, 1, 1, 0, 0); // TLR
    add(0, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // RTI
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // SELDR
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // SELIR
    add(0, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 0, 0, 0); // CAPIR
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 0); // EX1IR
    add(1, 0, 0, 0, 2'b00,  0, 0, 0, 1, 1, 1, 0, 1); // UPDIR
    add(0, 0, 0, 0, 2'b11,  0, 0, 0, 0, 1, 1, 0, 0); // RTI, BYPASS opcode
    add(1, 0, 0, 0, 2'b11,  0, 0, 0, 0, 1, 1, 0, 0); // SELDR
    add(0, 0, 0, 0, 2'b11,  0, 0, 0, 0, BYP, 1, 0, 0);    // CAPDR
    add(0, 0, 0, 1, 2'b11,  1, 1, ~BYP, 0, BYP, 1, 0, 0); // SHDR: capture bit
    add(0, 1, 0, 0, 2'b11,  1, 1, BYP, 0, BYP, 1, 0, 0);
    add(0, 0, 0, 1, 2'b11,  1, 1, ~BYP, 0, BYP, 1, 0, 0);
    add(0, 1, 0, 0, 2'b11,  1, 1, BYP, 0, BYP, 1, 0, 0);
    add(1, 1, 0, 0, 2'b11,  0, 0, 0, 0, 1, 1, 0, 0);      // EX1DR
    add(1, 0, 0, 0, 2'b11,  0, 0, 0, 0, 1, 1, ~BYP, 0);   // UPDDR
    add(1, 0, 0, 0, 2'b11,  0, 0, 0, 0, 1, 1, 0, 0);      // SELDR
    add(1, 0, 0, 0, 2'b11,  0, 0, 0, 0, 1, 1, 0, 0);      // SELIR
    add(1, 0, 0, 0, 2'b11,  0, 0, 0, 0, 1, 1, 0, 0);      // TLR

    #3 chk("reset_state", outs, 8'b0000_1100);
    #2 TRST_N = 1'b1;
    #5;

    b_updr = n_updr; b_upir = n_upir;
    for (int i = 0; i < vq.size(); i++) begin
      sel = vq[i].sel;
      step(vq[i].tms, vq[i].tdi, vq[i].irt, vq[i].bsrt);
      chk($sformatf("vec%0d", i), outs, vq[i].exp);
    end
    chk("table_updr_pulses", 8'(n_updr - b_updr), BYP ? 8'd2 : 8'd3);
    chk("table_upir_pulses", 8'(n_upir - b_upir), 8'd2);

    // Reset from SHDR with TCK low, then 5x TMS=1 from RTI must land in TLR.
    sel = 2'b01;
    do_reset();
    step(0); step(1); step(0); step(0, 0, 0, 1);
    chk("shdr_entry", outs, 8'b1110_0100);
    TRST_N = 1'b0;
    #1 chk("rst_in_shdr", outs, 8'b0000_1100);
    #3 TRST_N = 1'b1;
    #1;
    step(0);
    repeat (5) step(1);
    chk("tlr_after_5tms", outs, 8'b0000_1100);
    step(0); step(1); step(0); step(0);
    chk("shdr_from_tlr", {7'b0, shiftdr}, 8'd1);

    // Four shift clocks aligned to posedge TCK, then one update pulse.
    b_ckdr = n_ckdr; b_mis = n_mis; b_updr = n_updr;
    repeat (4) step(0);
    chk("ckdr_rises", 8'(n_ckdr - b_ckdr), 8'd4);
    chk("ckdr_misaligned", 8'(n_mis - b_mis), 8'd0);
    step(1); step(1);
    chk("upddr_level", {7'b0, updatedr}, 8'd1);
    step(1);
    chk("updr_one_pulse", 8'(n_updr - b_updr), 8'd1);

    // Reset in UPDDR with TCK low truncates the pulse; no second pulse afterwards.
    step(0); step(0); step(1);
    b_updr = n_updr;
    step(1);
    chk("upddr_pre_rst", {7'b0, updatedr}, 8'd1);
    TRST_N = 1'b0;
    #1 chk("updr_trunc", {7'b0, updatedr}, 8'd0);
    #3 TRST_N = 1'b1;
    #1;
    step(1); step(1);
    chk("updr_no_second", 8'(n_updr - b_updr), 8'd1);
    chk("post_rst_idle", outs, 8'b0000_1100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
